// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory-port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10
    } arb_state_e;

    typedef enum logic {
        OWN_F = 1'b0,
        OWN_M = 1'b1
    } arb_owner_e;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

endpackage

// File: rtl/mem_arb_perf.sv
// Performance counters for the memory arbiter: arbitration conflicts and busy cycles.
// Only instantiated when MEM_ARB_PERF_EN is defined.
module mem_arb_perf (
    input  logic        clk,
    input  logic        reset,
    input  logic        is_idle,
    input  logic        f_req,
    input  logic        m_req,
    output logic [31:0] perf_conflict_cnt,
    output logic [31:0] perf_busy_cnt
);

    // Count idle cycles with both requesters waiting, and every cycle an access is in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_conflict_cnt <= 32'd0;
            perf_busy_cnt     <= 32'd0;
        end else begin
            if (is_idle && f_req && m_req) begin
                perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
            end
            if (!is_idle) begin
                perf_busy_cnt <= perf_busy_cnt + 32'd1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single memory port between instruction fetch and the MEM stage.
// Data accesses win over fetches; one access outstanding at a time. A flush kills
// an in-flight fetch by silently consuming its response.
// Optional feature macro: MEM_ARB_PERF_EN adds perf_conflict_cnt / perf_busy_cnt.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              f_req,
    input  logic [AWIDTH-1:0] f_addr,
    output logic [DWIDTH-1:0] f_rdata,
    output logic              f_valid,
    output logic              f_stall,
    input  logic              m_req,
    input  logic              m_wren,
    input  logic [AWIDTH-1:0] m_addr,
    input  logic [DWIDTH-1:0] m_wdata,
    input  logic [1:0]        m_size,
    output logic [DWIDTH-1:0] m_rdata,
    output logic              m_valid,
    output logic              m_stall,
    input  logic              flush,
    output logic              mem_req,
    output logic              mem_wren,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    output logic [1:0]        mem_size,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DWIDTH-1:0] mem_rdata
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]       perf_conflict_cnt,
    output logic [31:0]       perf_busy_cnt
`endif
);

    arb_state_e state_r;
    arb_owner_e owner_r;
    logic       drop_r;
    logic       resp_s;

    // Access sequencer: grant in IDLE, present request in ISSUE, await response in WAIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            owner_r   <= OWN_F;
            drop_r    <= 1'b0;
            mem_req   <= 1'b0;
            mem_wren  <= 1'b0;
            mem_addr  <= {AWIDTH{1'b0}};
            mem_wdata <= {DWIDTH{1'b0}};
            mem_size  <= 2'b00;
        end else begin
            case (state_r)
                IDLE: begin
                    drop_r <= 1'b0;
                    if (m_req) begin
                        owner_r   <= OWN_M;
                        mem_req   <= 1'b1;
                        mem_wren  <= m_wren;
                        mem_addr  <= m_addr;
                        mem_wdata <= m_wdata;
                        mem_size  <= m_size;
                        state_r   <= ISSUE;
                    end else if (f_req) begin
                        owner_r   <= OWN_F;
                        mem_req   <= 1'b1;
                        mem_wren  <= 1'b0;
                        mem_addr  <= f_addr;
                        mem_wdata <= {DWIDTH{1'b0}};
                        mem_size  <= SIZE_WORD;
                        state_r   <= ISSUE;
                    end
                end
                ISSUE: begin
                    // A fetch request cannot be withdrawn once presented; mark it for discard.
                    if (flush && (owner_r == OWN_F)) begin
                        drop_r <= 1'b1;
                    end
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        state_r <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        drop_r  <= 1'b0;
                        state_r <= IDLE;
                    end else if (flush && (owner_r == OWN_F)) begin
                        drop_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    mem_req <= 1'b0;
                    drop_r  <= 1'b0;
                end
            endcase
        end
    end

    // Response routing; a flush coinciding with the response also kills it.
    assign resp_s  = !reset && mem_rvalid && (state_r == WAIT);
    assign f_valid = resp_s && (owner_r == OWN_F) && !drop_r && !flush;
    assign m_valid = resp_s && (owner_r == OWN_M);
    assign f_rdata = reset ? {DWIDTH{1'b0}} : mem_rdata;
    assign m_rdata = reset ? {DWIDTH{1'b0}} : mem_rdata;
    assign f_stall = f_req && !f_valid;
    assign m_stall = m_req && !m_valid;

`ifdef MEM_ARB_PERF_EN
    mem_arb_perf u_perf (
        .clk               (clk),
        .reset             (reset),
        .is_idle           (state_r == IDLE),
        .f_req             (f_req),
        .m_req             (m_req),
        .perf_conflict_cnt (perf_conflict_cnt),
        .perf_busy_cnt     (perf_busy_cnt)
    );
`endif

endmodule
